// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    // Fetch sequencer states: F0 issues the opcode read, F1/F2 capture and issue the
    // next byte, F3 captures the last byte, Valid presents the instruction.
    typedef enum logic [2:0] {
        StF0,
        StF1,
        StF2,
        StF3,
        StValid
    } ifu_state_e;

    localparam int unsigned INSTR_BYTES   = 3;
    localparam int unsigned INSTR_W       = 8 * INSTR_BYTES;

    // Byte-lane indices inside the assembled instruction word.
    localparam int unsigned OPCODE_LANE   = 2;
    localparam int unsigned OPERAND1_LANE = 1;
    localparam int unsigned OPERAND2_LANE = 0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control-unit handshake plus program-memory read port.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              fetch_en;
    logic              pc_load_en;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [23:0]       instr_word;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // The fetch unit itself.
    modport master (
        input  fetch_en, pc_load_en, pc_load_addr, mem_data, instr_ready,
        output mem_rd_en, mem_addr, instr_word, instr_pc, instr_valid
    );

    // Control unit and program memory.
    modport slave (
        output fetch_en, pc_load_en, pc_load_addr, mem_data, instr_ready,
        input  mem_rd_en, mem_addr, instr_word, instr_pc, instr_valid
    );
endinterface

// File: rtl/ifu_instr_buffer.sv
// Two-entry FIFO of completed {instr_pc, instr_word} pairs used for prefetching.
module ifu_instr_buffer
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_pc,
    input  logic [INSTR_W-1:0] i_push_word,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic               o_full,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_word
);
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               w_push;
    logic               w_pop;

    // Flush beats both pop and push; a pop on an empty buffer is ignored.
    assign w_pop  = i_pop && (r_count != 2'd0) && !i_flush;
    assign w_push = i_push && !i_flush && ((r_count != 2'd2) || w_pop);

    assign o_full  = (r_count == 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign {o_pc, o_word} = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= {RESET_PC, {INSTR_W{1'b0}}};
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_push_pc, i_push_word};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads three consecutive program-memory bytes per instruction
// and presents {opcode, operand1, operand2} with a valid/ready handshake.
// Optional feature macro IFU_PREFETCH_EN adds a 2-entry instruction buffer so fetching
// continues while earlier instructions wait for the control unit.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                       clk,
    input logic                       rst,
    instruction_fetch_unit_if.master  bus
);
`ifdef IFU_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    ifu_state_e         r_state;
    ifu_state_e         w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [7:0]         r_byte0;
    logic [7:0]         r_byte1;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_issue_addr;
    logic               w_done;
    logic               w_space;
    logic [INSTR_W-1:0] w_word;

    // Assemble the instruction from the two captured bytes and the byte arriving now.
    always_comb begin
        w_word = '0;
        w_word[OPCODE_LANE*8 +: 8]   = r_byte0;
        w_word[OPERAND1_LANE*8 +: 8] = r_byte1;
        w_word[OPERAND2_LANE*8 +: 8] = bus.mem_data;
    end

    // Next-state, pc update and read-strobe decode; a jump overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_issue      = 1'b0;
        w_issue_addr = r_pc;
        w_done       = 1'b0;
        if (bus.pc_load_en) begin
            w_state_next = StF0;
            w_pc_next    = bus.pc_load_addr;
        end else begin
            case (r_state)
                StF0: begin
                    if (bus.fetch_en && w_space) begin
                        w_issue      = 1'b1;
                        w_state_next = StF1;
                    end
                end
                StF1: begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_pc + ADDR_W'(1);
                    w_state_next = StF2;
                end
                StF2: begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_pc + ADDR_W'(2);
                    w_state_next = StF3;
                end
                StF3: begin
                    w_done       = 1'b1;
                    w_pc_next    = r_pc + ADDR_W'(INSTR_BYTES);
                    w_state_next = PREFETCH ? StF0 : StValid;
                end
                StValid: begin
                    if (bus.instr_ready) begin
                        w_state_next = StF0;
                    end
                end
                default: w_state_next = StF0;
            endcase
        end
    end

    // Strobe is forced low while reset is held so it drops immediately.
    assign bus.mem_rd_en = rst && w_issue;
    assign bus.mem_addr  = w_issue_addr;

    // Sequencer state and program counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StF0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Capture opcode and operand1 as they return; operand2 goes straight into w_word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte0 <= '0;
            r_byte1 <= '0;
        end else if (r_state == StF1) begin
            r_byte0 <= bus.mem_data;
        end else if (r_state == StF2) begin
            r_byte1 <= bus.mem_data;
        end
    end

`ifdef IFU_PREFETCH_EN
    logic               w_buf_full;
    logic               w_buf_valid;
    logic [ADDR_W-1:0]  w_buf_pc;
    logic [INSTR_W-1:0] w_buf_word;

    assign w_space = !w_buf_full;

    ifu_instr_buffer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_instr_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_done),
        .i_push_pc   (r_pc),
        .i_push_word (w_word),
        .i_pop       (bus.instr_ready),
        .i_flush     (bus.pc_load_en),
        .o_full      (w_buf_full),
        .o_valid     (w_buf_valid),
        .o_pc        (w_buf_pc),
        .o_word      (w_buf_word)
    );

    assign bus.instr_valid = w_buf_valid;
    assign bus.instr_pc    = w_buf_pc;
    assign bus.instr_word  = w_buf_word;
`else
    logic [INSTR_W-1:0] r_instr_word;
    logic [ADDR_W-1:0]  r_instr_pc;

    assign w_space = 1'b1;

    // Latch the completed instruction; it stays put for the whole Valid state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_word <= '0;
            r_instr_pc   <= RESET_PC;
        end else if (w_done) begin
            r_instr_word <= w_word;
            r_instr_pc   <= r_pc;
        end
    end

    assign bus.instr_valid = (r_state == StValid);
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_word  = r_instr_word;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (default build and IFU_PREFETCH_EN build).
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_W(8)) bus ();

    instruction_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [256];
    int         n_checks = 0;
    int         n_err    = 0;
    bit         run_cmp  = 1'b0;

    // Synchronous program memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_data <= ram[bus.mem_addr];
    end

    function automatic logic [23:0] instr_at(input logic [7:0] a);
        logic [7:0] a1;
        logic [7:0] a2;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        return {ram[a], ram[a1], ram[a2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.instr_valid;
        end
        check({name, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Model: m_pc is the next byte to fetch; m_k counts cycles into the current
    // instruction (0 idle/issuing, 1..3 bytes returning, 4 presented).
    logic [7:0]  m_pc   = 8'h00;
    logic [7:0]  m_ipc  = 8'h00;
    logic [23:0] m_word = 24'h0;
    int          m_k    = 0;

`ifndef IFU_PREFETCH_EN
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc <= 8'h00; m_k <= 0; m_word <= 24'h0; m_ipc <= 8'h00;
        end else if (bus.pc_load_en) begin
            m_pc <= bus.pc_load_addr; m_k <= 0;
        end else if (m_k == 0) begin
            if (bus.fetch_en) m_k <= 1;
        end else if (m_k < 3) begin
            m_k <= m_k + 1;
        end else if (m_k == 3) begin
            m_word <= instr_at(m_pc); m_ipc <= m_pc; m_pc <= m_pc + 8'd3; m_k <= 4;
        end else if (bus.instr_ready) begin
            m_k <= 0;
        end
    end

    always @(negedge clk) begin : cmp
        logic       exp_rd;
        logic [7:0] exp_addr;
        if (rst && run_cmp) begin
            check("instr_valid", 32'(bus.instr_valid), 32'(m_k == 4));
            if (m_k == 4) begin
                check("instr_word", 32'(bus.instr_word), 32'(m_word));
                check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
            end
            if (!bus.pc_load_en) begin
                exp_rd   = (m_k == 0) ? bus.fetch_en : (m_k < 3);
                exp_addr = m_pc + 8'(m_k);
                check("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
                if (exp_rd) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            end
        end
    end
`else
    // Prefetch model: the pc stream delivered to the control unit.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_pc <= 8'h00;
        else if (bus.pc_load_en) m_pc <= bus.pc_load_addr;
        else if (bus.instr_valid && bus.instr_ready) m_pc <= m_pc + 8'd3;
    end

    always @(negedge clk) begin
        if (rst && run_cmp && bus.instr_valid) begin
            check("instr_pc", 32'(bus.instr_pc), 32'(m_pc));
            check("instr_word", 32'(bus.instr_word), 32'(instr_at(m_pc)));
        end
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1);
    end

    initial begin
        bus.fetch_en = 1'b0; bus.pc_load_en = 1'b0; bus.pc_load_addr = 8'h00;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33;
        ram[8'h03] = 8'h44; ram[8'h04] = 8'h55; ram[8'h05] = 8'h66;
        ram[8'h06] = 8'h77; ram[8'h07] = 8'h88; ram[8'h08] = 8'h99;
        ram[8'h40] = 8'h01; ram[8'h41] = 8'h02; ram[8'h42] = 8'h03;
        ram[8'hFE] = 8'hAA; ram[8'hFF] = 8'hBB;

        #2;
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_word", 32'(bus.instr_word), 32'h0);
        check("rst_pc", 32'(bus.instr_pc), 32'h00);
        check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);

`ifndef IFU_PREFETCH_EN
        // Basic fetch of 11 22 33.
        after_edge();
        rst = 1'b1; bus.fetch_en = 1'b1; run_cmp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("issue_rd", 32'(bus.mem_rd_en), 32'd1);
            check("issue_addr", 32'(bus.mem_addr), 32'(i));
        end
        @(negedge clk);
        check("f3_rd", 32'(bus.mem_rd_en), 32'd0);
        @(negedge clk);
        check("c4_valid", 32'(bus.instr_valid), 32'd1);
        check("c4_word", 32'(bus.instr_word), 32'h112233);
        check("c4_pc", 32'(bus.instr_pc), 32'h00);

        // Hold in Valid, then one ready pulse.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_word", 32'(bus.instr_word), 32'h112233);
            check("hold_rd", 32'(bus.mem_rd_en), 32'd0);
        end
        after_edge(); bus.instr_ready = 1'b1;
        after_edge(); bus.instr_ready = 1'b0;
        @(negedge clk);
        check("next_addr", 32'(bus.mem_addr), 32'h03);
        wait_valid("second");
        check("second_word", 32'(bus.instr_word), 32'h445566);

        // Jump during F2, with fetch_en dropped during F1.
        after_edge(); bus.instr_ready = 1'b1;
        after_edge(); bus.instr_ready = 1'b0;
        after_edge(); bus.fetch_en = 1'b0;
        after_edge(); bus.fetch_en = 1'b1; bus.pc_load_en = 1'b1; bus.pc_load_addr = 8'h40;
        @(negedge clk);
        check("jump_f2_valid", 32'(bus.instr_valid), 32'd0);
        after_edge(); bus.pc_load_en = 1'b0;
        @(negedge clk);
        check("jump_valid", 32'(bus.instr_valid), 32'd0);
        check("jump_addr", 32'(bus.mem_addr), 32'h40);
        wait_valid("jump");
        check("jump_word", 32'(bus.instr_word), 32'h010203);
        check("jump_pc", 32'(bus.instr_pc), 32'h40);

        // Jump to FE together with ready: wrap-around fetch.
        ram[8'h00] = 8'hCC;
        after_edge(); bus.instr_ready = 1'b1; bus.pc_load_en = 1'b1; bus.pc_load_addr = 8'hFE;
        after_edge(); bus.instr_ready = 1'b0; bus.pc_load_en = 1'b0;
        @(negedge clk);
        check("wrap_issue", 32'(bus.mem_addr), 32'hFE);
        check("wrap_valid0", 32'(bus.instr_valid), 32'd0);
        wait_valid("wrap");
        check("wrap_word", 32'(bus.instr_word), 32'hAABBCC);
        check("wrap_pc", 32'(bus.instr_pc), 32'hFE);
        after_edge(); bus.instr_ready = 1'b1;
        after_edge(); bus.instr_ready = 1'b0;
        @(negedge clk);
        check("wrap_next", 32'(bus.mem_addr), 32'h01);

        // Reset during F1.
        after_edge();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("mid_rst_word", 32'(bus.instr_word), 32'h0);
        check("mid_rst_pc", 32'(bus.instr_pc), 32'h00);
        check("mid_rst_rd", 32'(bus.mem_rd_en), 32'd0);
        after_edge(); rst = 1'b1;
        @(negedge clk);
        check("post_rst_addr", 32'(bus.mem_addr), 32'h00);
        check("post_rst_rd", 32'(bus.mem_rd_en), 32'd1);
        bus.instr_ready = 1'b1;  // ready while not valid must be ignored
        wait_valid("post_rst");
        check("post_rst_word", 32'(bus.instr_word), 32'hCC2233);
        after_edge(); bus.instr_ready = 1'b0; bus.fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_rd", 32'(bus.mem_rd_en), 32'd0);
        end
`else
        begin
            logic [7:0] pcs [3];
            int         when [3];
            int         n = 0;
            after_edge();
            rst = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1; run_cmp = 1'b1;
            for (int i = 0; i < 40 && n < 3; i++) begin
                @(negedge clk);
                if (bus.instr_valid) begin
                    pcs[n] = bus.instr_pc; when[n] = i; n++;
                end
            end
            check("pf_count", 32'(n), 32'd3);
            if (n == 3) begin
                check("pf_pc0", 32'(pcs[0]), 32'h00);
                check("pf_pc1", 32'(pcs[1]), 32'h03);
                check("pf_pc2", 32'(pcs[2]), 32'h06);
                check("pf_gap_le4", 32'(when[1] - when[0] <= 4), 32'd1);
            end
            after_edge(); bus.instr_ready = 1'b0;
            repeat (12) @(negedge clk);
            check("pf_full_valid", 32'(bus.instr_valid), 32'd1);
            after_edge(); bus.pc_load_en = 1'b1; bus.pc_load_addr = 8'h40;
            after_edge(); bus.pc_load_en = 1'b0;
            @(negedge clk);
            check("pf_flush", 32'(bus.instr_valid), 32'd0);
            wait_valid("pf_jump");
            check("pf_jump_pc", 32'(bus.instr_pc), 32'h40);
            check("pf_jump_word", 32'(bus.instr_word), 32'h010203);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 Parameter: ADDR_W, default 8, program-memory address width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: fetch_en  input  1  permits starting a new instruction fetch.
REQ-006 Port: pc_load_en  input  1  jump request.
REQ-007 Port: pc_load_addr  input  ADDR_W  jump target.
REQ-008 Port: mem_rd_en  output  1  program-memory read strobe.
REQ-009 Port: mem_addr  output  ADDR_W  program-memory read address.
REQ-010 Port: mem_data  input  8  read data, valid exactly one cycle after the strobe (synchronous RAM).
REQ-011 Port: instr_word  output  24  assembled instruction: [23:16] opcode, [15:8] operand1, [7:0] operand2.
REQ-012 Port: instr_pc  output  ADDR_W  address of the opcode byte of instr_word.
REQ-013 Port: instr_valid  output  1  instr_word is presented to the control unit.
REQ-014 Port: instr_ready  input  1  control unit accepts instr_word.

Function
REQ-015 FSM states: F0, F1, F2, F3, VALID.
REQ-016 In F0 with fetch_en=1, the block SHALL drive mem_rd_en=1 and mem_addr=pc, then go to F1; with fetch_en=0 it SHALL stay in F0 with mem_rd_en=0.
REQ-017 F1: capture mem_data into byte0; issue pc+1.
REQ-018 F2: capture mem_data into byte1; issue pc+2.
REQ-019 F3: capture mem_data into byte2; mem_rd_en=0; set pc to pc+3; go to VALID.
REQ-020 Latency: instr_valid SHALL rise 4 cycles after the F0 issue edge.
REQ-021 In VALID, instr_valid=1; instr_word and instr_pc SHALL stay stable until the cycle instr_ready=1, then go to F0.
REQ-022 Address arithmetic SHALL be modulo 2^ADDR_W; an instruction at 8'hFE uses bytes FE, FF, 00.
REQ-023 Deasserting fetch_en mid-fetch (F1-F3) SHALL NOT abort the fetch; it is honoured only in F0.
REQ-024 pc_load_en=1 in any state SHALL do all of the following next edge: abort the fetch, clear instr_valid, set pc=pc_load_addr, enter F0. Data returned for the aborted read is discarded.
REQ-025 pc_load_en and instr_ready in the same cycle: pc_load_en wins; the presented instruction counts as consumed.
REQ-026 instr_ready while instr_valid=0 SHALL be ignored.

Reset
REQ-027 rst low SHALL immediately set all of the following: state=F0, pc=RESET_PC, instr_valid=0, instr_word=24'h0, instr_pc=RESET_PC, mem_rd_en=0, buffer empty.
REQ-028 Reset asserted mid-fetch SHALL discard partial bytes; the first fetch after release starts at RESET_PC.

Configuration
REQ-029 Macro IFU_PREFETCH_EN.
- Defined: completed instructions go into a 2-entry instruction buffer. Fetching continues while the buffer is not full and fetch_en=1. instr_valid = buffer not empty. Back-to-back accepts are sustained once two entries are buffered. pc_load_en flushes both entries.
- Undefined: no buffer; the next fetch starts only after the handshake (REQ-021).

Structure
REQ-030 Package ifu_pkg SHALL hold the FSM state enum, INSTR_BYTES=3, and the opcode/operand byte-lane index constants.
REQ-031 The prefetch buffer SHALL be the sub-module ifu_instr_buffer (2-deep FIFO of {instr_pc, instr_word}), instantiated only under IFU_PREFETCH_EN.

Verification
REQ-032 Reset, then fetch_en=1, RAM[0..2]=11,22,33 -> mem_addr 00,01,02 on consecutive cycles; instr_word=24'h112233, instr_pc=00, valid on cycle 4.
REQ-033 Hold instr_ready=0 for 10 cycles in VALID -> instr_word stable, mem_rd_en=0; ready pulse -> next fetch at 03.
REQ-034 pc_load_en with addr 8'h40 during F2 -> instr_valid stays 0; next issue at mem_addr=40; the partial bytes never appear.
REQ-035 pc_load_addr=8'hFE, RAM[FE,FF,00]=AA,BB,CC -> instr_word=24'hAABBCC, instr_pc=FE; next fetch at 01.
REQ-036 Drop rst during F1 -> outputs at reset values immediately; after release the first issue is at RESET_PC.
REQ-037 With IFU_PREFETCH_EN, ready held 1 -> successive instr_pc 00,03,06 with at most 4 cycles between the first two; pc_load flushes the buffer within 1 cycle.
